// File: rtl/instr_encoder.sv
// rtl/instr_encoder.sv - encodes instruction descriptors into 32-bit words and loads them into instruction memory
module instr_encoder #(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_last,
  input  logic [3:0]        op_sel,
  input  logic [4:0]        rd,
  input  logic [4:0]        rs1,
  input  logic [4:0]        rs2,
  input  logic [19:0]       imm,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic [ADDR_W:0]   word_count,
  output logic              busy,
  output logic              done,
  output logic              err_illegal,
  output logic              err_full
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W:0] LAST_FREE = (ADDR_W+1)'(DEPTH - 1);
  localparam logic [ADDR_W:0] FULL_CNT  = (ADDR_W+1)'(DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t              r_state;
  logic [ADDR_W-1:0]   r_ptr;
  logic [ADDR_W:0]     r_count;
  logic                r_we;
  logic [ADDR_W-1:0]   r_addr;
  logic [31:0]         r_wdata;
  logic                r_err_ill;
  logic                r_err_full;

  logic                w_accept;
  logic                w_legal;
  logic                w_last_free;
  logic [6:0]          w_opcode;
  logic [31:0]         w_wdata;

  assign w_accept    = in_valid && (r_state == S_RUN);
  assign w_legal     = (op_sel <= 4'd13);
  assign w_last_free = (r_count == LAST_FREE);

  // Opcode map skips 0101011 between SLT and BEQ.
  always_comb begin
    w_opcode = 7'b0000000;
    case (op_sel)
      4'd0:  w_opcode = 7'b0000011;
      4'd1:  w_opcode = 7'b0000111;
      4'd2:  w_opcode = 7'b0001011;
      4'd3:  w_opcode = 7'b0001111;
      4'd4:  w_opcode = 7'b0010011;
      4'd5:  w_opcode = 7'b0010111;
      4'd6:  w_opcode = 7'b0011011;
      4'd7:  w_opcode = 7'b0011111;
      4'd8:  w_opcode = 7'b0100011;
      4'd9:  w_opcode = 7'b0100111;
      4'd10: w_opcode = 7'b0101111;
      4'd11: w_opcode = 7'b0110011;
      4'd12: w_opcode = 7'b0110111;
      4'd13: w_opcode = 7'b0111011;
      default: w_opcode = 7'b0000000;
    endcase
  end

  always_comb begin
    w_wdata = 32'd0;
    case (op_sel)
      4'd0:                 w_wdata = {imm[11:0], rs1, 3'b000, rd, w_opcode};
      4'd1, 4'd10, 4'd11:   w_wdata = {imm[11:5], rs2, rs1, 3'b000, imm[4:0], w_opcode};
      4'd12:                w_wdata = {imm, 5'd0, w_opcode};
      4'd13:                w_wdata = {imm, rd, w_opcode};
      4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8, 4'd9:
                            w_wdata = {7'd0, rs2, rs1, 3'b000, rd, w_opcode};
      default:              w_wdata = 32'd0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_ptr      <= '0;
      r_count    <= '0;
      r_we       <= 1'b0;
      r_addr     <= '0;
      r_wdata    <= 32'd0;
      r_err_ill  <= 1'b0;
      r_err_full <= 1'b0;
    end else begin
      r_we <= 1'b0;
      case (r_state)
        S_IDLE, S_DONE: begin
          if (start) begin
            r_state    <= S_RUN;
            r_ptr      <= base_addr;
            r_count    <= '0;
            r_err_ill  <= 1'b0;
            r_err_full <= 1'b0;
          end
        end
        S_RUN: begin
          if (w_accept) begin
            if (w_legal) begin
              r_we    <= 1'b1;
              r_addr  <= r_ptr;
              r_wdata <= w_wdata;
              r_ptr   <= r_ptr + ADDR_W'(1);
              if (r_count != FULL_CNT)
                r_count <= r_count + (ADDR_W+1)'(1);
              // Filling the last free word ends the load; only an error if the program wanted more.
              if (w_last_free) begin
                r_state <= S_DONE;
                if (!in_last)
                  r_err_full <= 1'b1;
              end
            end else begin
              r_err_ill <= 1'b1;
            end
            if (in_last)
              r_state <= S_DONE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign in_ready    = (r_state == S_RUN);
  assign busy        = (r_state == S_RUN);
  assign done        = (r_state == S_DONE);
  assign imem_we     = r_we;
  assign imem_addr   = r_addr;
  assign imem_wdata  = r_wdata;
  assign word_count  = r_count;
  assign err_illegal = r_err_ill;
  assign err_full    = r_err_full;

endmodule
